// File: rtl/tlb_maint_unit.sv
//============================================================================
// Module      : tlb_maint_unit
// Description : Backend sequencer for the TLBSRCH / TLBRD / TLBWR / TLBFILL /
//               INVTLB maintenance instructions. Runs one operation at a time
//               against the tlb_top write, read, invtlb and search ports, and
//               hands the result back for CSR update.
// Revision    : 1.0 - initial release
//============================================================================
// TLB entry layout (ENTRY_W = 89 bits, MSB first):
//   [88:70] vppn  [69:64] ps  [63] g  [62:53] asid  [52] e
//   [51:26] page0 {ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0}
//   [25:0]  page1 {ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}
// Search result as consumed here (RESULT_W bits, MSB first): {found, index}
//============================================================================
`default_nettype none

module tlb_maint_unit #(
    parameter int TLBNUM   = 16,
    parameter int TLBIDLEN = 4,
    localparam int ENTRY_W  = 89,
    localparam int RESULT_W = 1 + TLBIDLEN
) (
    input  logic                clk,
    input  logic                reset,
    // maintenance request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [TLBIDLEN-1:0] req_index,
    input  logic                req_ne,
    input  logic [ENTRY_W-1:0]  req_entry,
    input  logic [18:0]         req_vppn,
    input  logic [9:0]          req_asid,
    input  logic [4:0]          req_invop,
    input  logic [31:0]         req_va,
    input  logic                flush,
    // tlb_top write port
    output logic                we,
    output logic [TLBIDLEN-1:0] w_index,
    output logic [ENTRY_W-1:0]  w_entry,
    // tlb_top read port
    output logic [TLBIDLEN-1:0] r_index,
    input  logic [ENTRY_W-1:0]  r_entry,
    // tlb_top invtlb port
    output logic                invtlb_valid,
    output logic [4:0]          invtlb_op,
    output logic [9:0]          invtlb_asid,
    output logic [31:0]         invtlb_va,
    // tlb_top search port 1
    output logic                s_valid,
    output logic [18:0]         s_vppn,
    output logic                s_va_bit12,
    output logic [9:0]          s_asid,
    input  logic [RESULT_W-1:0] s_result,
    input  logic                s_ok,
    // response
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [2:0]          resp_op,
    output logic                resp_found,
    output logic [TLBIDLEN-1:0] resp_index,
    output logic [ENTRY_W-1:0]  resp_entry
);

    localparam int            E_BIT   = 52;
    localparam logic [2:0]    OP_SRCH = 3'd0;
    localparam logic [2:0]    OP_RD   = 3'd1;
    localparam logic [2:0]    OP_WR   = 3'd2;
    localparam logic [2:0]    OP_FILL = 3'd3;
    localparam logic [2:0]    OP_INV  = 3'd4;
    localparam logic [TLBIDLEN-1:0] CNT_LAST = TLBIDLEN'(TLBNUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SRCH  = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_INV   = 3'd4,
        S_DRAIN = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [TLBIDLEN-1:0]   fill_cnt_q, fill_cnt_d;
    logic [2:0]            op_q, op_d;
    logic [TLBIDLEN-1:0]   index_q, index_d;      // RD/WR index, or fill slot for FILL
    logic                  ne_q, ne_d;
    logic [ENTRY_W-1:0]    entry_q, entry_d;
    logic [18:0]           vppn_q, vppn_d;
    logic [9:0]            asid_q, asid_d;
    logic [4:0]            invop_q, invop_d;
    logic [31:0]           va_q, va_d;
    logic                  found_q, found_d;
    logic [TLBIDLEN-1:0]   res_index_q, res_index_d;
    logic [ENTRY_W-1:0]    rd_entry_q, rd_entry_d;

    // Next-state, request capture and result capture
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = (fill_cnt_q == CNT_LAST) ? '0 : fill_cnt_q + 1'b1;
        op_d        = op_q;
        index_d     = index_q;
        ne_d        = ne_q;
        entry_d     = entry_q;
        vppn_d      = vppn_q;
        asid_d      = asid_q;
        invop_d     = invop_q;
        va_d        = va_q;
        found_d     = found_q;
        res_index_d = res_index_q;
        rd_entry_d  = rd_entry_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    // FILL picks its victim slot from the counter value at acceptance
                    index_d     = (req_op == OP_FILL) ? fill_cnt_q : req_index;
                    ne_d        = req_ne;
                    entry_d     = req_entry;
                    vppn_d      = req_vppn;
                    asid_d      = req_asid;
                    invop_d     = req_invop;
                    va_d        = req_va;
                    found_d     = 1'b0;
                    res_index_d = '0;
                    rd_entry_d  = '0;
                    case (req_op)
                        OP_SRCH:         state_d = S_SRCH;
                        OP_RD:           state_d = S_RD;
                        OP_WR, OP_FILL:  state_d = S_WR;
                        OP_INV:          state_d = S_INV;
                        default:         state_d = S_RESP;
                    endcase
                end
            end
            S_SRCH: begin
                // A flush abandons the search even if the result lands this cycle
                if (flush) begin
                    state_d = S_IDLE;
                end else if (s_ok) begin
                    found_d     = s_result[RESULT_W-1];
                    res_index_d = s_result[TLBIDLEN-1:0];
                    state_d     = S_RESP;
                end
            end
            S_RD: begin
                rd_entry_d = r_entry;
                found_d    = r_entry[E_BIT];
                state_d    = S_RESP;
            end
            S_WR:    state_d = S_DRAIN;
            S_INV:   state_d = S_DRAIN;
            // One quiet cycle so the TLB caches settle before a following search
            S_DRAIN: state_d = S_RESP;
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port drive, each interface gated to zero outside its own state
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        we           = 1'b0;
        w_index      = '0;
        w_entry      = '0;
        r_index      = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        invtlb_asid  = '0;
        invtlb_va    = '0;
        s_valid      = 1'b0;
        s_vppn       = '0;
        s_va_bit12   = 1'b0;
        s_asid       = '0;
        resp_valid   = 1'b0;
        resp_op      = '0;
        resp_found   = 1'b0;
        resp_index   = '0;
        resp_entry   = '0;

        case (state_q)
            S_SRCH: begin
                s_valid = 1'b1;
                s_vppn  = vppn_q;
                s_asid  = asid_q;
            end
            S_RD: r_index = index_q;
            S_WR: begin
                we             = 1'b1;
                w_index        = index_q;
                w_entry        = entry_q;
                w_entry[E_BIT] = ~ne_q;
            end
            S_INV: begin
                invtlb_valid = 1'b1;
                invtlb_op    = invop_q;
                invtlb_asid  = asid_q;
                invtlb_va    = va_q;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_op    = op_q;
                resp_found = found_q;
                resp_index = res_index_q;
                resp_entry = rd_entry_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            op_q        <= '0;
            index_q     <= '0;
            ne_q        <= 1'b0;
            entry_q     <= '0;
            vppn_q      <= '0;
            asid_q      <= '0;
            invop_q     <= '0;
            va_q        <= '0;
            found_q     <= 1'b0;
            res_index_q <= '0;
            rd_entry_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            op_q        <= op_d;
            index_q     <= index_d;
            ne_q        <= ne_d;
            entry_q     <= entry_d;
            vppn_q      <= vppn_d;
            asid_q      <= asid_d;
            invop_q     <= invop_d;
            va_q        <= va_d;
            found_q     <= found_d;
            res_index_q <= res_index_d;
            rd_entry_q  <= rd_entry_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlb_maint_unit.sv
//============================================================================
// Module      : tb_tlb_maint_unit
// Description : Directed self-checking bench for tlb_maint_unit with a small
//               behavioural tlb_top (array, read, search, invtlb op 0/1/5).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlb_maint_unit;

    localparam int EW = 89;
    localparam int EB = 52;
    localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2,
                           OP_FILL = 3'd3, OP_INV = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_ne, flush;
    logic [2:0]    req_op;
    logic [3:0]    req_index;
    logic [EW-1:0] req_entry;
    logic [18:0]   req_vppn;
    logic [9:0]    req_asid;
    logic [4:0]    req_invop;
    logic [31:0]   req_va;
    logic          we;
    logic [3:0]    w_index, r_index;
    logic [EW-1:0] w_entry, r_entry;
    logic          invtlb_valid;
    logic [4:0]    invtlb_op;
    logic [9:0]    invtlb_asid;
    logic [31:0]   invtlb_va;
    logic          s_valid, s_va_bit12, s_ok;
    logic [18:0]   s_vppn;
    logic [9:0]    s_asid;
    logic [4:0]    s_result;
    logic          resp_valid, resp_ready, resp_found;
    logic [2:0]    resp_op;
    logic [3:0]    resp_index;
    logic [EW-1:0] resp_entry;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tlb_maint_unit #(.TLBNUM(16), .TLBIDLEN(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_ne(req_ne), .req_entry(req_entry),
        .req_vppn(req_vppn), .req_asid(req_asid), .req_invop(req_invop),
        .req_va(req_va), .flush(flush),
        .we(we), .w_index(w_index), .w_entry(w_entry),
        .r_index(r_index), .r_entry(r_entry),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va),
        .s_valid(s_valid), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
        .s_asid(s_asid), .s_result(s_result), .s_ok(s_ok),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_found(resp_found), .resp_index(resp_index), .resp_entry(resp_entry)
    );

    // Behavioural tlb_top
    logic [EW-1:0] tlb [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) tlb[i] <= '0;
        end else begin
            if (we) tlb[w_index] <= w_entry;
            if (invtlb_valid) begin
                for (int i = 0; i < 16; i++) begin
                    if (invtlb_op == 5'd0 || invtlb_op == 5'd1)
                        tlb[i][EB] <= 1'b0;
                    else if (invtlb_op == 5'd5 && !tlb[i][63] &&
                             tlb[i][62:53] == invtlb_asid &&
                             tlb[i][88:70] == invtlb_va[31:13])
                        tlb[i][EB] <= 1'b0;
                end
            end
        end
    end
    assign r_entry = tlb[r_index];

    always_comb begin
        s_result = '0;
        for (int i = 15; i >= 0; i--) begin
            if (tlb[i][EB] && tlb[i][88:70] == s_vppn &&
                (tlb[i][63] || tlb[i][62:53] == s_asid))
                s_result = {1'b1, 4'(i)};
        end
    end

    // Search latency: s_ok on the sok_lat-th cycle of s_valid (0 = never)
    int sok_lat;
    int sok_cnt;
    assign s_ok = s_valid && (sok_lat != 0) && (sok_cnt == sok_lat - 1);
    always @(posedge clk) begin
        if (reset || !s_valid || s_ok) sok_cnt <= 0;
        else                           sok_cnt <= sok_cnt + 1;
    end

    // Cycle counter since reset release
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Mid-cycle monitors of the side-effect ports
    int we_cnt = 0, inv_cnt = 0, sv_cnt = 0, rv_cnt = 0;
    logic [3:0]    mw_idx;
    logic [EW-1:0] mw_ent;
    logic [4:0]    mi_op;
    logic [9:0]    mi_asid, ms_asid;
    logic [31:0]   mi_va;
    logic [18:0]   ms_vppn;
    logic          ms_b12;
    always @(negedge clk) begin
        if (we)           begin we_cnt++;  mw_idx = w_index; mw_ent = w_entry; end
        if (invtlb_valid) begin inv_cnt++; mi_op = invtlb_op; mi_asid = invtlb_asid; mi_va = invtlb_va; end
        if (s_valid)      begin sv_cnt++;  ms_vppn = s_vppn; ms_asid = s_asid; ms_b12 = s_va_bit12; end
        if (resp_valid)   rv_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_entry(input logic [18:0] vppn, input logic [9:0] asid, input logic g);
        logic [EW-1:0] e;
        e         = '0;
        e[88:70]  = vppn;
        e[63]     = g;
        e[62:53]  = asid;
        e[EB]     = 1'b1;
        e[51:32]  = {1'b0, vppn};
        return e;
    endfunction

    int acc_cyc;

    // Call just after a negedge; returns 1ns after the accepting posedge
    task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic ne,
                         input logic [EW-1:0] ent, input logic [18:0] vppn,
                         input logic [9:0] asid, input logic [4:0] invop, input logic [31:0] va);
        logic ok;
        req_op = op; req_index = idx; req_ne = ne; req_entry = ent;
        req_vppn = vppn; req_asid = asid; req_invop = invop; req_va = va;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            if (req_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        #1 req_valid = 1'b0;
        chk("accept", ok, 1'b1);
    endtask

    // Returns at the first negedge with resp_valid; lat = edges after accept
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 1; n <= 30 && lat < 0; n++) begin
            @(negedge clk);
            if (resp_valid) lat = n - 1;
        end
        chk("resp_arrives", (lat >= 0), 1'b1);
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_resp", req_ready, 1'b1);
    endtask

    initial begin
        int lat, s0, i0, w0, r0, bad, a1;
        logic [EW-1:0] e1, e2, e3;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_index = '0; req_ne = 1'b0;
        req_entry = '0; req_vppn = '0; req_asid = '0; req_invop = '0; req_va = '0;
        flush = 1'b0; resp_ready = 1'b0; sok_lat = 1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_inv", invtlb_valid, 1'b0);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_w_index", w_index, 4'd0);
        reset = 1'b0;
        @(negedge clk);

        // WR index 5, ne=0
        e1 = mk_entry(19'h1234, 10'd3, 1'b0);
        issue(OP_WR, 4'd5, 1'b0, e1, '0, '0, '0, '0);
        wait_resp(lat);
        chk("wr_latency", lat, 2);
        chk("wr_resp_op", resp_op, OP_WR);
        complete();
        chk("wr_pulses", we_cnt, 1);
        chk("wr_index", mw_idx, 4'd5);
        chk("wr_e", mw_ent[EB], 1'b1);
        chk("wr_vppn", mw_ent[88:70], 19'h1234);

        // SRCH with 3-cycle search latency, then 10-cycle response stall
        sok_lat = 3; s0 = sv_cnt;
        issue(OP_SRCH, 4'd0, 1'b0, '0, 19'h1234, 10'd3, '0, '0);
        wait_resp(lat);
        chk("srch_sv_cycles", sv_cnt - s0, 3);
        chk("srch_s_vppn", ms_vppn, 19'h1234);
        chk("srch_s_asid", ms_asid, 10'd3);
        chk("srch_bit12", ms_b12, 1'b0);
        chk("srch_found", resp_found, 1'b1);
        chk("srch_index", resp_index, 4'd5);
        chk("srch_op", resp_op, OP_SRCH);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_found === 1'b1 &&
                  resp_index === 4'd5 && resp_op === OP_SRCH && s_valid === 1'b0))
                bad++;
        end
        chk("resp_hold_stable", bad, 0);
        complete();

        // WR with ne=1 then RD -> invalid
        sok_lat = 1;
        issue(OP_WR, 4'd5, 1'b1, e1, '0, '0, '0, '0);
        wait_resp(lat); complete();
        issue(OP_RD, 4'd5, 1'b0, '0, '0, '0, '0, '0);
        wait_resp(lat);
        chk("rd_latency", lat, 1);
        chk("rd_ne1_found", resp_found, 1'b0);
        chk("rd_ne1_e", resp_entry[EB], 1'b0);
        complete();

        // WR with ne=0 then RD -> valid entry back
        issue(OP_WR, 4'd5, 1'b0, e1, '0, '0, '0, '0);
        wait_resp(lat); complete();
        issue(OP_RD, 4'd5, 1'b0, '0, '0, '0, '0, '0);
        wait_resp(lat);
        chk("rd_found", resp_found, 1'b1);
        chk("rd_vppn", resp_entry[88:70], 19'h1234);
        chk("rd_asid", resp_entry[62:53], 10'd3);
        chk("rd_op", resp_op, OP_RD);
        complete();

        // FILL x2, 20 cycles apart; req_index must be ignored
        e2 = mk_entry(19'h0200, 10'd3, 1'b0);
        w0 = we_cnt;
        issue(OP_FILL, 4'hF, 1'b0, e2, '0, '0, '0, '0);
        a1 = acc_cyc;
        wait_resp(lat);
        chk("fill_latency", lat, 2);
        chk("fill_op", resp_op, OP_FILL);
        complete();
        chk("fill_pulses", we_cnt - w0, 1);
        chk("fill1_index", mw_idx, 4'(a1 % 16));
        chk("fill1_e", mw_ent[EB], 1'b1);
        while (cyc < a1 + 20) @(negedge clk);
        e3 = mk_entry(19'h0300, 10'd3, 1'b0);
        issue(OP_FILL, 4'd0, 1'b0, e3, '0, '0, '0, '0);
        chk("fill2_accept_cycle", acc_cyc, a1 + 20);
        wait_resp(lat); complete();
        chk("fill2_index", mw_idx, 4'((a1 + 20) % 16));

        // SRCH of va 0x00400000 finds the first fill
        issue(OP_SRCH, 4'd0, 1'b0, '0, 19'h0200, 10'd3, '0, '0);
        wait_resp(lat);
        chk("pre_inv_found", resp_found, 1'b1);
        chk("pre_inv_index", resp_index, 4'(a1 % 16));
        complete();

        // INVTLB op 5
        i0 = inv_cnt; w0 = we_cnt;
        issue(OP_INV, 4'd0, 1'b0, '0, '0, 10'd3, 5'd5, 32'h0040_0000);
        wait_resp(lat);
        chk("inv_latency", lat, 2);
        chk("inv_op_resp", resp_op, OP_INV);
        complete();
        chk("inv_pulses", inv_cnt - i0, 1);
        chk("inv_op", mi_op, 5'd5);
        chk("inv_asid", mi_asid, 10'd3);
        chk("inv_va", mi_va, 32'h0040_0000);
        chk("inv_no_we", we_cnt - w0, 0);

        issue(OP_SRCH, 4'd0, 1'b0, '0, 19'h0200, 10'd3, '0, '0);
        wait_resp(lat);
        chk("post_inv_found", resp_found, 1'b0);
        complete();
        issue(OP_SRCH, 4'd0, 1'b0, '0, 19'h0300, 10'd3, '0, '0);
        wait_resp(lat);
        chk("other_fill_found", resp_found, 1'b1);
        chk("other_fill_index", resp_index, 4'((a1 + 20) % 16));
        complete();

        // Reserved op goes straight to a not-found response
        issue(3'd7, 4'd0, 1'b0, '0, '0, '0, '0, '0);
        wait_resp(lat);
        chk("rsvd_latency", lat, 0);
        chk("rsvd_op", resp_op, 3'd7);
        chk("rsvd_found", resp_found, 1'b0);
        complete();

        // Flush during a search that never completes
        sok_lat = 0; r0 = rv_cnt; s0 = sv_cnt;
        issue(OP_SRCH, 4'd0, 1'b0, '0, 19'h1234, 10'd3, '0, '0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_req_ready", req_ready, 1'b1);
        chk("flush_s_valid", s_valid, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("flush_sv_cycles", sv_cnt - s0, 2);
        chk("flush_no_resp", rv_cnt - r0, 0);

        // Flush while a response is pending drops it
        @(negedge clk);
        issue(3'd6, 4'd0, 1'b0, '0, '0, '0, '0, '0);
        wait_resp(lat);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("resp_flush_valid", resp_valid, 1'b0);
        chk("resp_flush_ready", req_ready, 1'b1);
        chk("total_we_pulses", we_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tlb_maint_unit.md
Name: tlb_maint_unit

Overview:
- Backend sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits between the commit-stage CSR/TLB instruction path and tlb_top, acting as the initiator on tlb_top's write, read, invtlb and search port 1.
- Serialises one maintenance operation at a time, handles search-port wait states, and returns results for CSR update (TLBIDX, TLBEHI/TLBELO/ASID).

Parameters:
- TLBNUM, 16, number of TLB entries; power of two.
- TLBIDLEN, 4, log2(TLBNUM); index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  maintenance request
- req_ready  out  1  unit idle, request accepted when valid&ready
- req_op  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV (5-7 reserved)
- req_index  in  TLBIDLEN  CSR TLBIDX.index (RD/WR)
- req_ne  in  1  CSR TLBIDX.NE (WR/FILL)
- req_entry  in  tlb_entry_t  entry assembled from CSRs (WR/FILL)
- req_vppn  in  19  CSR TLBEHI.vppn (SRCH)
- req_asid  in  10  CSR ASID (SRCH/INV)
- req_invop  in  5  invtlb op
- req_va  in  32  invtlb va
- flush  in  1  pipeline flush
- we, w_index, w_entry  out  1/TLBIDLEN/tlb_entry_t  tlb_top write port
- r_index  out  TLBIDLEN  tlb_top read index
- r_entry  in  tlb_entry_t  tlb_top read data
- invtlb_valid, invtlb_op, invtlb_asid, invtlb_va  out  1/5/10/32  tlb_top invtlb port
- s_valid, s_vppn, s_va_bit12, s_asid  out  1/19/1/10  search request toward tlb_top port 1 (muxed upstream)
- s_result  in  tlb_result_t  search result
- s_ok  in  1  search result valid
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_op  out  3  op of completed request
- resp_found  out  1  SRCH hit / RD entry e bit
- resp_index  out  TLBIDLEN  SRCH hit index
- resp_entry  out  tlb_entry_t  RD data

Behaviour:
- Reset (async): state IDLE; fill counter 0. Outputs: we=0, invtlb_valid=0, s_valid=0, resp_valid=0, req_ready=1. Other outputs 0.
- Fill counter: free-running, increments every clk, wraps TLBNUM-1 -> 0. Its value is captured at FILL acceptance.
- States: IDLE, SRCH, RD, WR, INV, DRAIN, RESP. req_ready=1 only in IDLE.
- IDLE: on accept, latch all req_* fields. Next state by op: SRCH->SRCH, RD->RD, WR/FILL->WR, INV->INV. Reserved ops go to RESP with resp_found=0.
- SRCH:
  - s_valid=1, s_vppn=latched vppn, s_va_bit12=0, s_asid=latched asid, held stable.
  - Stays until s_ok=1 (expected 1-3 cycles); then captures s_result.found/index and goes to RESP.
  - flush in SRCH -> IDLE next cycle, no response, s_valid drops.
- RD:
  - r_index=latched index for 1 cycle; r_entry sampled at end of that cycle.
  - resp_entry=r_entry; resp_found=r_entry.e. -> RESP.
- WR:
  - we=1 for exactly 1 cycle.
  - w_index = latched index (WR) or captured fill counter (FILL).
  - w_entry = latched entry with e forced to ~req_ne.
  - -> DRAIN.
- INV: invtlb_valid=1 for exactly 1 cycle with latched op/asid/va -> DRAIN.
- DRAIN: 1 idle cycle so tcache/L2 contents settle before any new search. -> RESP.
- RESP: resp_valid=1, fields stable until resp_ready=1; then -> IDLE. resp_valid=resp_ready=1 in same cycle completes; req_ready rises next cycle.
- flush is ignored outside SRCH: WR/INV side effects, once accepted, always complete. A flush in RESP drops the response (-> IDLE).
- Unused ports hold 0 when not in their state (no stale we/invtlb pulses).
- Async reset in any state: pulses abort immediately; no partial write is retried.

Test Plan:
- Reset, then WR with req_index=5, req_ne=0, entry vppn=0x1234 -> we high exactly 1 cycle, w_index=5, w_entry.e=1; resp_valid 2 cycles after acceptance with resp_op=2.
- WR then SRCH with vppn=0x1234, matching asid, s_ok delayed 3 cycles -> s_valid held 3 cycles; resp_found=1, resp_index=5.
- RD index=5 after WR with req_ne=1 -> resp_found=0, resp_entry.e=0. RD index=5 after WR with ne=0 -> resp_entry.vppn=0x1234.
- FILL accepted at cycle N after reset (counter = N mod 16) -> w_index = N mod 16; a second FILL 20 cycles later -> index (N+20) mod 16.
- INV op=5, asid=3, va=0x00400000 -> single invtlb_valid pulse with those values; a following SRCH of that va -> resp_found=0.
- SRCH with s_ok never asserted, flush at cycle 2 -> IDLE, no resp_valid, req_ready=1 next cycle. resp_ready held low for 10 cycles -> resp fields stable and req_ready stays 0 throughout.
